layer_sequencer: RTL and testbench

Sequences one fully-connected layer of the MNIST accelerator's node array. On a start pulse it issues the bias read, streams input/weight read addresses for every input, waits for the nodes' done flag, then writes the N_NODES results back to memory. The top-level controller sits above it and runs it once per layer with different base addresses and input counts.

---
 rtl/nn_pkg.sv | 39 +++
 rtl/layer_sequencer_if.sv | 40 ++++
 rtl/addr_stride_gen.sv | 29 ++
 rtl/layer_sequencer.sv | 177 +++++++++++++++++
 tb/tb_layer_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the node-array layer sequencing
package nn_pkg;

  localparam int N_NODES = 10;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 10;
  localparam int WD_MAX  = 255;
  localparam int WD_W    = 8;
  localparam int IDX_W   = 4;

  // Watchdog compare points: the pulse is raised one cycle before the bailout cycle
  localparam logic [WD_W-1:0]  WD_WARN  = WD_W'(WD_MAX - 2);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WD_MAX - 1);
  localparam logic [IDX_W-1:0] NODE_END = IDX_W'(N_NODES);

  // Memory map used by the top-level controller for each layer pass
  localparam logic [ADDR_W-1:0] L1_X_BASE   = 16'h0000;
  localparam logic [ADDR_W-1:0] L1_W_BASE   = 16'h1000;
  localparam logic [ADDR_W-1:0] L1_B_BASE   = 16'hE000;
  localparam logic [ADDR_W-1:0] L1_OUT_BASE = 16'hF000;
  localparam logic [ADDR_W-1:0] L2_X_BASE   = 16'hF000;
  localparam logic [ADDR_W-1:0] L2_W_BASE   = 16'h3000;
  localparam logic [ADDR_W-1:0] L2_B_BASE   = 16'hE010;
  localparam logic [ADDR_W-1:0] L2_OUT_BASE = 16'hF100;
  localparam logic [ADDR_W-1:0] L3_X_BASE   = 16'hF100;
  localparam logic [ADDR_W-1:0] L3_W_BASE   = 16'h3100;
  localparam logic [ADDR_W-1:0] L3_B_BASE   = 16'hE020;
  localparam logic [ADDR_W-1:0] L3_OUT_BASE = 16'hF200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_MAC,
    ST_WAIT_DONE,
    ST_WRITE,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// rtl/layer_sequencer_if.sv - request, node and memory signals of one layer pass
interface layer_sequencer_if;
  import nn_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  in_count;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] out_base;
  logic              done_flag_node2c;

  logic              busy;
  logic              layer_done;
  logic              timeout_err;
  logic              rd_en_c2mem;
  logic [ADDR_W-1:0] x_addr_c2mem;
  logic [ADDR_W-1:0] w_addr_c2mem;
  logic [ADDR_W-1:0] b_addr_c2mem;
  logic              head_c2node;
  logic              data_select_c2node;
  logic              wr_en_c2mem;
  logic [ADDR_W-1:0] out_addr_c2mem;
  logic [IDX_W-1:0]  out_idx_c2node;

  modport master (
    output start, in_count, x_base, w_base, b_base, out_base, done_flag_node2c,
    input  busy, layer_done, timeout_err, rd_en_c2mem, x_addr_c2mem, w_addr_c2mem,
           b_addr_c2mem, head_c2node, data_select_c2node, wr_en_c2mem,
           out_addr_c2mem, out_idx_c2node
  );

  modport slave (
    input  start, in_count, x_base, w_base, b_base, out_base, done_flag_node2c,
    output busy, layer_done, timeout_err, rd_en_c2mem, x_addr_c2mem, w_addr_c2mem,
           b_addr_c2mem, head_c2node, data_select_c2node, wr_en_c2mem,
           out_addr_c2mem, out_idx_c2node
  );

endinterface

// File: rtl/addr_stride_gen.sv
// rtl/addr_stride_gen.sv - loadable address pointer advancing by a fixed stride
module addr_stride_gen
  import nn_pkg::*;
(
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              load_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;

  // Load wins over step; the sum wraps modulo 2^ADDR_W
  always_ff @(posedge clock) begin
    if (rst) begin
      addr_q <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
    end else if (step_i) begin
      addr_q <= addr_q + stride_i;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - bias/MAC/wait/write sequencing of one fully-connected layer
module layer_sequencer
  import nn_pkg::*;
(
  input logic               clock,
  input logic               rst,
  layer_sequencer_if.slave  bus
);

  state_t            state_q;
  logic [CNT_W-1:0]  in_count_q;
  logic [CNT_W-1:0]  idx_q;
  logic [IDX_W-1:0]  jdx_q;
  logic [WD_W-1:0]   wd_q;

  logic              busy_q;
  logic              layer_done_q;
  logic              timeout_err_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] x_addr_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic              head_q;
  logic              sel_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [IDX_W-1:0]  out_idx_q;

  logic              gen_load_d;
  logic              mac_step_d;
  logic              wr_step_d;
  logic [ADDR_W-1:0] x_ptr;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] out_ptr;

  // Pointer control: a pointer steps in the cycle its current value is registered onto the bus
  always_comb begin
    gen_load_d = 1'b0;
    mac_step_d = 1'b0;
    wr_step_d  = 1'b0;
    case (state_q)
      ST_IDLE:      gen_load_d = bus.start;
      ST_BIAS:      mac_step_d = (in_count_q != '0);
      ST_MAC:       mac_step_d = (idx_q != in_count_q);
      ST_WAIT_DONE: wr_step_d  = bus.done_flag_node2c && (wd_q != WD_LAST);
      ST_WRITE:     wr_step_d  = (jdx_q != NODE_END);
      default:      ;
    endcase
  end

  addr_stride_gen u_x_gen (
    .clock(clock), .rst(rst), .base_i(bus.x_base), .stride_i(ADDR_W'(1)),
    .load_i(gen_load_d), .step_i(mac_step_d), .addr_o(x_ptr)
  );

  addr_stride_gen u_w_gen (
    .clock(clock), .rst(rst), .base_i(bus.w_base), .stride_i(ADDR_W'(N_NODES)),
    .load_i(gen_load_d), .step_i(mac_step_d), .addr_o(w_ptr)
  );

  addr_stride_gen u_out_gen (
    .clock(clock), .rst(rst), .base_i(bus.out_base), .stride_i(ADDR_W'(1)),
    .load_i(gen_load_d), .step_i(wr_step_d), .addr_o(out_ptr)
  );

  // Layer FSM with registered outputs; strobes and addresses default low each cycle
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      in_count_q    <= '0;
      idx_q         <= '0;
      jdx_q         <= '0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_en_q       <= 1'b0;
      x_addr_q      <= '0;
      w_addr_q      <= '0;
      b_addr_q      <= '0;
      head_q        <= 1'b0;
      sel_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      out_addr_q    <= '0;
      out_idx_q     <= '0;
    end else begin
      layer_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_en_q       <= 1'b0;
      x_addr_q      <= '0;
      w_addr_q      <= '0;
      b_addr_q      <= '0;
      head_q        <= 1'b0;
      sel_q         <= 1'b0;
      wr_en_q       <= 1'b0;
      out_addr_q    <= '0;
      out_idx_q     <= '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q    <= ST_BIAS;
            in_count_q <= bus.in_count;
            idx_q      <= '0;
            jdx_q      <= '0;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            b_addr_q   <= bus.b_base;
            head_q     <= 1'b1;
            sel_q      <= 1'b1;
          end
        end
        ST_BIAS, ST_MAC: begin
          if (mac_step_d) begin
            state_q  <= ST_MAC;
            rd_en_q  <= 1'b1;
            x_addr_q <= x_ptr;
            w_addr_q <= w_ptr;
            idx_q    <= idx_q + 1'b1;
          end else begin
            state_q <= ST_WAIT_DONE;
            wd_q    <= '0;
          end
        end
        ST_WAIT_DONE: begin
          if (wd_q == WD_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (bus.done_flag_node2c) begin
            state_q    <= ST_WRITE;
            wr_en_q    <= 1'b1;
            out_addr_q <= out_ptr;
            out_idx_q  <= '0;
            jdx_q      <= IDX_W'(1);
          end else begin
            wd_q <= wd_q + 1'b1;
            if (wd_q == WD_WARN) begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wr_step_d) begin
            wr_en_q    <= 1'b1;
            out_addr_q <= out_ptr;
            out_idx_q  <= jdx_q;
            jdx_q      <= jdx_q + 1'b1;
          end else begin
            state_q      <= ST_FINISH;
            layer_done_q <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy               = busy_q;
  assign bus.layer_done         = layer_done_q;
  assign bus.timeout_err        = timeout_err_q;
  assign bus.rd_en_c2mem        = rd_en_q;
  assign bus.x_addr_c2mem       = x_addr_q;
  assign bus.w_addr_c2mem       = w_addr_q;
  assign bus.b_addr_c2mem       = b_addr_q;
  assign bus.head_c2node        = head_q;
  assign bus.data_select_c2node = sel_q;
  assign bus.wr_en_c2mem        = wr_en_q;
  assign bus.out_addr_c2mem     = out_addr_q;
  assign bus.out_idx_c2node     = out_idx_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;

  logic clock;
  logic rst;
  int   n_pass;
  int   n_total;

  layer_sequencer_if bus ();

  layer_sequencer dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, ".ctrl"},
          {21'd0, bus.busy, bus.layer_done, bus.timeout_err, bus.rd_en_c2mem,
           bus.head_c2node, bus.data_select_c2node, bus.wr_en_c2mem, bus.out_idx_c2node},
          32'd0);
    check({tag, ".xw"}, {bus.x_addr_c2mem, bus.w_addr_c2mem}, 32'd0);
    check({tag, ".bo"}, {bus.b_addr_c2mem, bus.out_addr_c2mem}, 32'd0);
  endtask

  // Full pass: start, bias, cnt MAC reads, done on first wait cycle, 10 writes, finish
  task automatic run_layer(input string nm, input logic [9:0] cnt,
                           input logic [15:0] xb, input logic [15:0] wb,
                           input logic [15:0] bb, input logic [15:0] ob,
                           input bit inject);
    bus.in_count = cnt;
    bus.x_base   = xb;
    bus.w_base   = wb;
    bus.b_base   = bb;
    bus.out_base = ob;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check({nm, ".bias.rd"},   bus.rd_en_c2mem, 1);
    check({nm, ".bias.addr"}, bus.b_addr_c2mem, bb);
    check({nm, ".bias.head"}, bus.head_c2node, 1);
    check({nm, ".bias.sel"},  bus.data_select_c2node, 1);
    check({nm, ".bias.busy"}, bus.busy, 1);
    for (int i = 0; i < int'(cnt); i++) begin
      if (inject && i == 1) begin
        bus.start            = 1'b1;
        bus.done_flag_node2c = 1'b1;
        bus.x_base           = 16'h7777;
        bus.in_count         = 10'd1;
      end
      tick();
      bus.start            = 1'b0;
      bus.done_flag_node2c = 1'b0;
      bus.x_base           = xb;
      bus.in_count         = cnt;
      check($sformatf("%s.mac%0d.rd", nm, i), bus.rd_en_c2mem, 1);
      check($sformatf("%s.mac%0d.x", nm, i), bus.x_addr_c2mem, 16'(xb + i));
      check($sformatf("%s.mac%0d.w", nm, i), bus.w_addr_c2mem, 16'(wb + i * 10));
      check($sformatf("%s.mac%0d.hs", nm, i), {bus.head_c2node, bus.data_select_c2node}, 0);
    end
    tick();
    check({nm, ".wait.rd"},   bus.rd_en_c2mem, 0);
    check({nm, ".wait.wr"},   bus.wr_en_c2mem, 0);
    check({nm, ".wait.busy"}, bus.busy, 1);
    bus.done_flag_node2c = 1'b1;
    tick();
    bus.done_flag_node2c = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check($sformatf("%s.wr%0d.en", nm, j),   bus.wr_en_c2mem, 1);
      check($sformatf("%s.wr%0d.addr", nm, j), bus.out_addr_c2mem, 16'(ob + j));
      check($sformatf("%s.wr%0d.idx", nm, j),  bus.out_idx_c2node, j);
      check($sformatf("%s.wr%0d.done", nm, j), bus.layer_done, 0);
      tick();
    end
    check({nm, ".fin.done"}, bus.layer_done, 1);
    check({nm, ".fin.busy"}, bus.busy, 1);
    check({nm, ".fin.wr"},   bus.wr_en_c2mem, 0);
    tick();
    check({nm, ".idle.busy"}, bus.busy, 0);
    check({nm, ".idle.done"}, bus.layer_done, 0);
  endtask

  initial begin
    int to_at;
    int idle_at;
    int pulses;
    int bad;

    n_pass               = 0;
    n_total              = 0;
    rst                  = 1'b1;
    bus.start            = 1'b0;
    bus.in_count         = '0;
    bus.x_base           = '0;
    bus.w_base           = '0;
    bus.b_base           = '0;
    bus.out_base         = '0;
    bus.done_flag_node2c = 1'b0;
    tick();
    tick();
    check_all_idle("reset");
    rst = 1'b0;
    tick();
    check_all_idle("post_reset");

    // Basic pass, 3 inputs: done on first wait cycle gives layer_done 16 cycles after start
    run_layer("basic", 10'd3, 16'h0100, 16'h2000, 16'h3000, 16'h4000, 1'b0);

    // Zero inputs: bias then directly to wait
    run_layer("zero", 10'd0, 16'h0500, 16'h0600, 16'h0700, 16'h0800, 1'b0);

    // Watchdog: done withheld, timeout pulse on wait cycle 255, idle on 256
    bus.in_count = 10'd0;
    bus.b_base   = 16'h1234;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("wd.bias.addr", bus.b_addr_c2mem, 16'h1234);
    to_at   = 0;
    idle_at = 0;
    pulses  = 0;
    bad     = 0;
    for (int w = 1; w <= 300; w++) begin
      tick();
      if (bus.timeout_err === 1'b1) begin
        pulses++;
        if (to_at == 0) to_at = w;
      end
      if (bus.wr_en_c2mem !== 1'b0 || bus.layer_done !== 1'b0) bad++;
      if (bus.busy === 1'b0 && idle_at == 0) idle_at = w;
    end
    check("wd.pulse_cycle", to_at, 255);
    check("wd.pulse_count", pulses, 1);
    check("wd.idle_cycle",  idle_at, 256);
    check("wd.no_writes",   bad, 0);

    // Start and done pulsed mid-MAC are ignored
    run_layer("inject", 10'd3, 16'h0100, 16'h2000, 16'h3000, 16'h4000, 1'b1);

    // Input address wraps at 16 bits
    run_layer("wrap", 10'd4, 16'hFFFE, 16'hFFF0, 16'h0010, 16'hFFFC, 1'b0);

    // Reset in the middle of MAC, then a fresh pass
    bus.in_count = 10'd5;
    bus.x_base   = 16'h0A00;
    bus.w_base   = 16'h0B00;
    bus.b_base   = 16'h0C00;
    bus.out_base = 16'h0D00;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("rst.mac2.x", bus.x_addr_c2mem, 16'h0A02);
    check("rst.mac2.w", bus.w_addr_c2mem, 16'h0B14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_idle("rst.mid");
    tick();
    check_all_idle("rst.after");
    run_layer("fresh", 10'd2, 16'h0040, 16'h0080, 16'h00C0, 16'h0100, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
